line_buffer_window: RTL and testbench
=====================================

// Module: line_buffer_window
// PURPOSE
//  Parametrised multi-line buffer for KxK convolution windows in the DeepLabV3+ datapath.
//  Stores KERNEL-1 previous image rows and emits, per accepted pixel, a vertical column of KERNEL taps (same column, consecutive rows).
//  Advances only on valid_in and tracks column/row position; supports mid-frame clear and continuous back-to-back frames.
//  Sits between the pixel stream source and the horizontal window/MAC stage.
// PARAMETERS
//  IMAGE_WIDTH   220  pixels per row
//  IMAGE_HEIGHT  220  rows per frame
//  KERNEL        3    window height; taps = KERNEL, stored lines = KERNEL-1 (KERNEL >= 2)
//  DIN_WIDTH     32   bits per pixel
//  COL_W         8    column counter width, 2**COL_W >= IMAGE_WIDTH
//  ROW_W         8    row counter width, 2**ROW_W >= IMAGE_HEIGHT
// PORTS
//  clk         in   1                  clock, rising edge
//  reset       in   1                  asynchronous, active-low reset
//  clear       in   1                  synchronous frame restart (counters/outputs only)
//  valid_in    in   1                  data_in holds a pixel this cycle
//  data_in     in   DIN_WIDTH          pixel, raster order
//  taps_out    out  KERNEL*DIN_WIDTH   slice k = pixel k rows above current, same column
//  valid_out   out  1                  taps_out holds a complete column
//  col_out     out  COL_W              column of pixel in taps_out
//  row_out     out  ROW_W              row of pixel in taps_out (slice 0)
//  frame_done  out  1                  1-cycle pulse with last pixel of frame
// BEHAVIOUR
//  - Storage: KERNEL-1 lines x IMAGE_WIDTH entries, addressed by col counter (no shifting of full lines).
//  - Accept cycle (valid_in=1, clear=0, reset high): read line[k][col] for all k;
//    write line[0][col]<=data_in, line[k][col]<=old line[k-1][col] for k>=1.
//  - Latency 1 cycle: taps_out slice 0 = data_in, slice k = old line[k-1][col]; col_out/row_out = pre-increment counters.
//  - valid_out=1 the cycle after an accept iff row >= KERNEL-1 at accept; otherwise 0. No accept -> valid_out=0, taps_out hold value.
//  - col increments per accept, wraps IMAGE_WIDTH-1 -> 0 and increments row; row wraps IMAGE_HEIGHT-1 -> 0.
//  - frame_done=1 with the output of the pixel at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), coincident with valid_out.
//  - Back-to-back frames: no bubble needed; previous-frame data in the lines is never marked valid (row gate).
//  - clear=1: col,row<=0, valid_out,frame_done<=0 next cycle; line memory not cleared; clear wins over
//    simultaneous valid_in (pixel dropped).
//  - reset=0 (any time, incl. mid-frame): immediately taps_out=0, valid_out=0, frame_done=0, col_out=0, row_out=0,
//    internal counters=0; line memory contents undefined (need not be reset, may map to RAM).
//  - Gaps in valid_in of any length do not alter the tap sequence.
//  - No backpressure: downstream must accept every valid_out cycle.
// TESTING (IMAGE_WIDTH=4, IMAGE_HEIGHT=4, KERNEL=3, DIN_WIDTH=8)
//  1 Stream 0..15 continuous -> 8 valid_out beats; first {s2,s1,s0}={0,4,8} at row2 col0;
//    last {7,11,15} row3 col3 with frame_done=1; no valid_out for pixels 0..7.
//  2 Same stream with random 0-5 cycle valid_in gaps -> identical valid_out tap sequence, each 1 cycle after its accept.
//  3 Stream 32 pixels (frames A=0..15, B=100..115) -> 16 valid_out beats, 2 frame_done;
//    first frame-B beat {100,104,108}, no frame-A data in frame-B taps.
//  4 Feed 6 pixels, pulse clear with valid_in=1 (value 99), then feed 0..15 -> 99 dropped;
//    output identical to test 1.
//  5 Assert reset mid-row 2 -> outputs 0 same cycle without clk edge; after release, stream 0..15 -> matches test 1.
//  6 KERNEL=5, IMAGE_HEIGHT=6, stream 0..23 -> first valid at row4 col0 taps {0,4,8,12,16}; 8 beats total.

Source files
------------

// File: rtl/line_buffer_window.sv
// rtl/line_buffer_window.sv - KERNEL-line buffer emitting one vertical tap column per accepted pixel
module line_buffer_window #(
  parameter int IMAGE_WIDTH  = 220,
  parameter int IMAGE_HEIGHT = 220,
  parameter int KERNEL       = 3,
  parameter int DIN_WIDTH    = 32,
  parameter int COL_W        = 8,
  parameter int ROW_W        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          valid_in,
  input  logic [DIN_WIDTH-1:0]          data_in,
  output logic [KERNEL*DIN_WIDTH-1:0]   taps_out,
  output logic                          valid_out,
  output logic [COL_W-1:0]              col_out,
  output logic [ROW_W-1:0]              row_out,
  output logic                          frame_done
);

  localparam int ADDR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  // line_mem[k] holds the row k+1 above the current one; no reset so it can map to RAM
  logic [DIN_WIDTH-1:0] line_mem [KERNEL-1][IMAGE_WIDTH];

  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  logic [ADDR_W-1:0]            addr;
  logic                         accept;
  logic                         last_col;
  logic                         last_row;
  logic [KERNEL*DIN_WIDTH-1:0]  taps_next;

  assign addr     = col[ADDR_W-1:0];
  assign accept   = valid_in & ~clear;
  assign last_col = (col == COL_W'(IMAGE_WIDTH - 1));
  assign last_row = (row == ROW_W'(IMAGE_HEIGHT - 1));

  always_comb begin
    taps_next = '0;
    taps_next[DIN_WIDTH-1:0] = data_in;
    for (int k = 1; k < KERNEL; k++) begin
      taps_next[k*DIN_WIDTH +: DIN_WIDTH] = line_mem[k-1][addr];
    end
  end

  // Each column slot ripples one line deeper per accept instead of shifting whole lines
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][addr] <= data_in;
      for (int k = 1; k < KERNEL - 1; k++) begin
        line_mem[k][addr] <= line_mem[k-1][addr];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      taps_out   <= '0;
      valid_out  <= 1'b0;
      col_out    <= '0;
      row_out    <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else if (valid_in) begin
      taps_out   <= taps_next;
      // Rows above the current one still hold the previous frame until row KERNEL-1
      valid_out  <= (row >= ROW_W'(KERNEL - 1));
      col_out    <= col;
      row_out    <= row;
      frame_done <= last_col && last_row;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_window.sv
// tb/tb_line_buffer_window.sv - scoreboard bench for line_buffer_window (K=3 and K=5 instances)
module tb_line_buffer_window;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        valid_in, valid6;
  logic [7:0]  data_in, data6;
  logic [23:0] taps_out;
  logic [39:0] taps6;
  logic        valid_out, valid_out6;
  logic [7:0]  col_out, row_out, col6, row6;
  logic        frame_done, frame_done6;

  always #5 clk = ~clk;

  line_buffer_window #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL(3), .DIN_WIDTH(8),
                       .COL_W(8), .ROW_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .taps_out(taps_out), .valid_out(valid_out), .col_out(col_out), .row_out(row_out),
    .frame_done(frame_done));

  line_buffer_window #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(6), .KERNEL(5), .DIN_WIDTH(8),
                       .COL_W(8), .ROW_W(8)) dut6 (
    .clk(clk), .reset(reset), .clear(1'b0), .valid_in(valid6), .data_in(data6),
    .taps_out(taps6), .valid_out(valid_out6), .col_out(col6), .row_out(row6),
    .frame_done(frame_done6));

  typedef struct {
    logic [39:0] taps;
    int          col;
    int          row;
    bit          fd;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [39:0] log0[$];
  logic [39:0] log1[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          beats0, fds0, beats1, fds1;
  int          hist[2][6][4];
  int          mcol[2];
  int          mrow[2];
  int          kk[2] = '{3, 5};
  int          hh[2] = '{4, 6};
  exp_t        e0, e1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcol[i] = 0;
      mrow[i] = 0;
    end
  endtask

  task automatic model_accept(input int id, input int v);
    exp_t e;
    int   r, c;
    r = mrow[id];
    c = mcol[id];
    hist[id][r][c] = v;
    if (r >= kk[id] - 1) begin
      e.taps = '0;
      for (int k = 0; k < kk[id]; k++) e.taps[8*k +: 8] = 8'(hist[id][r-k][c]);
      e.col = c;
      e.row = r;
      e.fd  = (r == hh[id] - 1) && (c == 3);
      e.due = cyc + 1;
      if (id == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    c++;
    if (c == 4) begin
      c = 0;
      r++;
      if (r == hh[id]) r = 0;
    end
    mcol[id] = c;
    mrow[id] = r;
  endtask

  task automatic send(input int id, input int v, input int gap);
    repeat (gap) begin
      @(negedge clk);
      valid_in = 1'b0;
      valid6   = 1'b0;
    end
    @(negedge clk);
    if (id == 0) begin
      valid_in = 1'b1;
      data_in  = 8'(v);
      valid6   = 1'b0;
    end else begin
      valid6   = 1'b1;
      data6    = 8'(v);
      valid_in = 1'b0;
    end
    model_accept(id, v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      valid6   = 1'b0;
    end
  endtask

  task automatic start_test();
    beats0 = 0; fds0 = 0; beats1 = 0; fds1 = 0;
    log0.delete();
    log1.delete();
  endtask

  task automatic check_frame1(input string t);
    chk({t, "_beats"}, beats0, 8);
    chk({t, "_frame_done"}, fds0, 1);
    chk({t, "_drain"}, q0.size(), 0);
    if (log0.size() == 8) begin
      chk({t, "_first"}, log0[0], 40'h000408);
      chk({t, "_last"}, log0[7], 40'h070B0F);
    end
  endtask

  // Monitor for the K=3 instance: every beat must match the head of the queue on its due cycle
  always @(negedge clk) begin
    if (valid_out) begin
      beats0++;
      if (frame_done) fds0++;
      log0.push_back(40'(taps_out));
      if (q0.size() == 0) begin
        chk("k3_unexpected_beat", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("k3_taps", taps_out, e0.taps);
        chk("k3_col", col_out, e0.col);
        chk("k3_row", row_out, e0.row);
        chk("k3_frame_done", frame_done, e0.fd);
        chk("k3_latency", cyc, e0.due);
      end
    end else begin
      if (frame_done) chk("k3_fd_without_valid", 1, 0);
      if (q0.size() > 0 && q0[0].due <= cyc) begin
        e0 = q0.pop_front();
        chk("k3_missing_beat", 0, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_out6) begin
      beats1++;
      if (frame_done6) fds1++;
      log1.push_back(taps6);
      if (q1.size() == 0) begin
        chk("k5_unexpected_beat", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("k5_taps", taps6, e1.taps);
        chk("k5_col", col6, e1.col);
        chk("k5_row", row6, e1.row);
        chk("k5_frame_done", frame_done6, e1.fd);
        chk("k5_latency", cyc, e1.due);
      end
    end else begin
      if (frame_done6) chk("k5_fd_without_valid", 1, 0);
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        e1 = q1.pop_front();
        chk("k5_missing_beat", 0, 1);
      end
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0;
    valid_in = 1'b0; valid6 = 1'b0; data_in = '0; data6 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_taps", taps_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_col", col_out, 0);
    chk("rst_row", row_out, 0);
    chk("rst_fd", frame_done, 0);
    reset = 1'b1;

    // 1: continuous frame
    start_test();
    for (int v = 0; v < 16; v++) send(0, v, 0);
    idle(4);
    check_frame1("t1");

    // 2: same frame with random gaps
    start_test();
    for (int v = 0; v < 16; v++) send(0, v, $urandom_range(0, 5));
    idle(4);
    check_frame1("t2");

    // 3: two back-to-back frames
    start_test();
    for (int v = 0; v < 16; v++) send(0, v, 0);
    for (int v = 100; v < 116; v++) send(0, v, 0);
    idle(4);
    chk("t3_beats", beats0, 16);
    chk("t3_frame_done", fds0, 2);
    chk("t3_drain", q0.size(), 0);
    if (log0.size() == 16) chk("t3_first_b", log0[8], 40'h64686C);

    // 4: clear mid-frame with a simultaneous pixel that must be dropped
    start_test();
    for (int v = 0; v < 6; v++) send(0, v, 0);
    @(negedge clk);
    clear = 1'b1; valid_in = 1'b1; data_in = 8'd99;
    mcol[0] = 0; mrow[0] = 0;
    @(negedge clk);
    clear = 1'b0; valid_in = 1'b0;
    for (int v = 0; v < 16; v++) send(0, v, 0);
    idle(4);
    check_frame1("t4");

    // 5: asynchronous reset while a beat is on the outputs
    start_test();
    for (int v = 0; v < 10; v++) send(0, v, 0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk("t5_pre_valid", valid_out, 1);
    reset = 1'b0;
    #1;
    chk("t5_async_valid", valid_out, 0);
    chk("t5_async_taps", taps_out, 0);
    chk("t5_async_col", col_out, 0);
    chk("t5_async_row", row_out, 0);
    chk("t5_async_fd", frame_done, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_test();
    for (int v = 0; v < 16; v++) send(0, v, 0);
    idle(4);
    check_frame1("t5");

    // 6: K=5, six-row frame
    start_test();
    for (int v = 0; v < 24; v++) send(1, v, 0);
    idle(4);
    chk("t6_beats", beats1, 8);
    chk("t6_frame_done", fds1, 1);
    chk("t6_drain", q1.size(), 0);
    if (log1.size() == 8) chk("t6_first", log1[0], 40'h0004080C10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
